// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage, the instruction ROM and decode.
// master = fetch stage side, slave = ROM/decode/redirect side.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

interface fetch_stage_if;
  logic [`WORD_WIDTH-1:0] imem_addr;
  logic [`WORD_WIDTH-1:0] imem_instr;
  logic                   redirect_valid;
  logic [`WORD_WIDTH-1:0] redirect_pc;
  logic                   if_valid;
  logic                   if_ready;
  logic [`WORD_WIDTH-1:0] if_instr;
  logic [`WORD_WIDTH-1:0] if_pc;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// PC generator and IF/ID register in front of a combinational instruction ROM.
// Optional macro FETCH_PERF_EN enables the fetched-instruction counter on fetch_count.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module fetch_stage #(
  parameter logic [`WORD_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_en,
  fetch_stage_if.master          bus,
  output logic [`WORD_WIDTH-1:0] fetch_count
);

  localparam logic [`WORD_WIDTH-1:0] ONE = {{(`WORD_WIDTH-1){1'b0}}, 1'b1};

  logic [`WORD_WIDTH-1:0] pc;
  logic [`WORD_WIDTH-1:0] if_instr_q;
  logic [`WORD_WIDTH-1:0] if_pc_q;
  logic                   if_valid_q;
  logic                   load;

  assign load = fetch_en & (~if_valid_q | bus.if_ready) & ~bus.redirect_valid;

  // Redirect beats load; when neither happens a pending entry is held until
  // decode takes it, so stalls never drop or duplicate an instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
    end else if (bus.redirect_valid) begin
      pc         <= bus.redirect_pc;
      if_valid_q <= 1'b0;
    end else if (load) begin
      if_instr_q <= bus.imem_instr;
      if_pc_q    <= pc;
      if_valid_q <= 1'b1;
      pc         <= pc + ONE;
    end else begin
      if_valid_q <= if_valid_q & ~bus.if_ready;
    end
  end

  assign bus.imem_addr = pc;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.if_pc     = if_pc_q;

`ifdef FETCH_PERF_EN
  logic [`WORD_WIDTH-1:0] fetch_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= '0;
    end else if (load) begin
      fetch_count_q <= fetch_count_q + ONE;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: cycle table with an in-order fetch scoreboard,
// followed by hand-written reset/stall/redirect sequences.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module tb_fetch_stage;
  localparam int W = `WORD_WIDTH;

  typedef struct {
    logic         en;
    logic         rdy;
    logic         rv;
    logic [W-1:0] rpc;
    logic         ld;
    logic         v;
    logic [W-1:0] ipc;
    logic [W-1:0] pc;
  } vec_t;

  typedef struct {
    logic [W-1:0] pc;
    logic [W-1:0] instr;
  } sb_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         fetch_en;
  logic [W-1:0] fetch_count;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .bus         (bus),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rom(input logic [W-1:0] a);
    if (a == 7) return '0;
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  assign bus.imem_instr = rom(bus.imem_addr);

  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;
  vec_t tbl[$];
  sb_t  sbq[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_count();
`ifdef FETCH_PERF_EN
    return W'(exp_cnt);
`else
    return '0;
`endif
  endfunction

  task automatic add(input logic en, input logic rdy, input logic rv, input logic [W-1:0] rpc,
                     input logic ld, input logic v, input logic [W-1:0] ipc, input logic [W-1:0] pc);
    vec_t r;
    r.en = en; r.rdy = rdy; r.rv = rv; r.rpc = rpc;
    r.ld = ld; r.v = v; r.ipc = ipc; r.pc = pc;
    tbl.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic         cur_v;
    logic [W-1:0] cur_pc;
    sb_t          e;

    // en rdy rv rpc | ld v if_pc pc
    for (int i = 0; i < 8; i++) add(1, 1, 0, 0, 1, 1, W'(i), W'(i + 1));
    add(1, 1, 1, 2, 0, 0, 0, 2);
    add(1, 0, 0, 0, 1, 1, 2, 3);
    add(1, 0, 0, 0, 0, 1, 2, 3);
    add(1, 0, 0, 0, 0, 1, 2, 3);
    add(1, 0, 0, 0, 0, 1, 2, 3);
    add(1, 1, 0, 0, 1, 1, 3, 4);
    add(1, 1, 1, 1, 0, 0, 0, 1);
    add(1, 1, 0, 0, 1, 1, 1, 2);
    add(1, 1, 1, 5, 0, 0, 0, 5);
    add(1, 1, 0, 0, 1, 1, 5, 6);
    add(1, 0, 1, 9, 0, 0, 0, 9);
    add(1, 0, 0, 0, 1, 1, 9, 10);
    add(1, 0, 0, 0, 0, 1, 9, 10);
    add(0, 0, 0, 0, 0, 1, 9, 10);
    add(0, 1, 0, 0, 0, 0, 0, 10);
    add(0, 1, 0, 0, 0, 0, 0, 10);
    add(1, 1, 0, 0, 1, 1, 10, 11);
    add(1, 1, 1, 32'hFFFF_FFFF, 0, 0, 0, 32'hFFFF_FFFF);
    add(1, 1, 0, 0, 1, 1, 32'hFFFF_FFFF, 0);
    add(1, 1, 0, 0, 1, 1, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 1);

    rst = 1'b1; fetch_en = 1'b1;
    bus.if_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h1234;
    step();
    step();
    chk("rst_valid", {{(W-1){1'b0}}, bus.if_valid}, 0);
    chk("rst_instr", bus.if_instr, 0);
    chk("rst_if_pc", bus.if_pc, 0);
    chk("rst_addr", bus.imem_addr, 0);
    chk("rst_count", fetch_count, 0);

    rst = 1'b0;
    cur_v = 1'b0; cur_pc = '0;
    foreach (tbl[i]) begin
      fetch_en = tbl[i].en;
      bus.if_ready = tbl[i].rdy;
      bus.redirect_valid = tbl[i].rv;
      bus.redirect_pc = tbl[i].rpc;
      if (cur_v && tbl[i].rdy) begin
        if (sbq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb_empty row %0d: transfer with no expected entry", i);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("sb_pc row %0d", i), bus.if_pc, e.pc);
          chk($sformatf("sb_instr row %0d", i), bus.if_instr, e.instr);
        end
      end
      if (tbl[i].rv) sbq.delete();
      if (tbl[i].ld) begin
        e.pc = cur_pc; e.instr = rom(cur_pc);
        sbq.push_back(e);
        exp_cnt++;
      end
      step();
      chk($sformatf("addr row %0d", i), bus.imem_addr, tbl[i].pc);
      chk($sformatf("valid row %0d", i), {{(W-1){1'b0}}, bus.if_valid}, {{(W-1){1'b0}}, tbl[i].v});
      if (tbl[i].v) chk($sformatf("if_pc row %0d", i), bus.if_pc, tbl[i].ipc);
      chk($sformatf("count row %0d", i), fetch_count, exp_count());
      cur_v = tbl[i].v; cur_pc = tbl[i].pc;
    end

    // fetch into a stall, redirect during the stall, then reset during a stall
    fetch_en = 1'b1; bus.if_ready = 1'b0; bus.redirect_valid = 1'b0;
    exp_cnt++;
    step();
    chk("seq_ld_valid", {{(W-1){1'b0}}, bus.if_valid}, 1);
    chk("seq_ld_if_pc", bus.if_pc, 1);
    chk("seq_ld_instr", bus.if_instr, rom(1));
    chk("seq_ld_addr", bus.imem_addr, 2);

    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h77;
    step();
    chk("seq_rdr_valid", {{(W-1){1'b0}}, bus.if_valid}, 0);
    chk("seq_rdr_addr", bus.imem_addr, 32'h77);
    chk("seq_rdr_count", fetch_count, exp_count());

    bus.redirect_valid = 1'b0;
    exp_cnt++;
    step();
    chk("seq_tgt_if_pc", bus.if_pc, 32'h77);
    chk("seq_tgt_instr", bus.if_instr, rom(32'h77));
    chk("seq_tgt_addr", bus.imem_addr, 32'h78);

    rst = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h123;
    exp_cnt = 0;
    step();
    chk("seq_rst_valid", {{(W-1){1'b0}}, bus.if_valid}, 0);
    chk("seq_rst_instr", bus.if_instr, 0);
    chk("seq_rst_if_pc", bus.if_pc, 0);
    chk("seq_rst_addr", bus.imem_addr, 0);
    chk("seq_rst_count", fetch_count, 0);

    rst = 1'b0; bus.redirect_valid = 1'b0; bus.if_ready = 1'b1;
    exp_cnt++;
    step();
    chk("seq_post_valid", {{(W-1){1'b0}}, bus.if_valid}, 1);
    chk("seq_post_if_pc", bus.if_pc, 0);
    chk("seq_post_instr", bus.if_instr, rom(0));
    chk("seq_post_addr", bus.imem_addr, 1);
    chk("seq_post_count", fetch_count, exp_count());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
